rob_multi_commit: RTL and testbench
===================================

// Module: rob_multi_commit
// PURPOSE
// Parametrised reorder buffer, successor to the single-commit ROB. Sits between decode (allocation),
// the writeback ports (completion) and commit (regfile, store buffer, fetch redirect).
// Supports WB_PORTS completion ports, up to COMMIT_WIDTH in-order commits per cycle, an occupancy
// count and writeback bypass on operand lookup.
// PARAMETERS
// ROB_DEPTH     16           entries; power of two, >= 4
// COMMIT_WIDTH  2            maximum commits per cycle, 1..4
// WB_PORTS      2            completion ports, 1..4
// SB_DEPTH      8            store buffer entries; sets width of discard mask and SB index
// XCPT_ADDR     32'h00000200 redirect PC on exception
// PORTS  (IW=$clog2(ROB_DEPTH), SW=$clog2(SB_DEPTH), C=COMMIT_WIDTH, P=WB_PORTS)
// clk_i             in   1       clock
// rstn_i            in   1       asynchronous, active-low reset
// alloc_valid_i     in   1       decode allocation request
// alloc_pc_i        in   32      instruction PC
// alloc_rd_i        in   5       destination register
// alloc_we_i        in   1       writes rd
// alloc_store_i     in   1       instruction is a store
// alloc_ready_o     out  1       ~full_o && ~redirect_o
// alloc_idx_o       out  IW      entry index given to this allocation
// wb_valid_i        in   P       per-port completion
// wb_idx_i          in   P*IW    target entry per port
// wb_result_i       in   P*32    result per port
// wb_new_pc_i       in   P*32    branch target per port
// wb_taken_i        in   P       branch taken per port
// wb_xcpt_i         in   P       exception per port
// wb_sb_idx_i       in   P*SW    store buffer slot per port
// cm_valid_o        out  C       commit slot k valid (slot 0 is oldest)
// cm_pc_o           out  C*32    committed PC
// cm_rd_o           out  C*5     committed rd
// cm_we_o           out  C       committed write enable
// cm_result_o       out  C*32    committed result
// cm_store_o        out  C       committed store
// cm_sb_idx_o       out  C*SW    committed store buffer slot
// redirect_o        out  1       a committing slot is a taken branch or an exception
// redirect_pc_o     out  32      new_pc, or XCPT_ADDR on exception
// discard_sb_o      out  SB_DEPTH  store buffer slots of flushed stores
// rs_addr_i         in   2*5     two source-register lookups
// rs_hit_o          out  2       an in-flight producer exists
// rs_idx_o          out  2*IW    youngest producer entry
// rs_ready_o        out  2       producer completed, or completing this cycle
// rs_data_o         out  2*32    producer result (bypassed from a WB port when completing now)
// count_o           out  IW+1    valid entries
// full_o            out  1       count_o == ROB_DEPTH
// BEHAVIOUR
// - Reset: head = tail = 0; all entries invalid; every output 0; alloc_ready_o = 1 after reset.
// - Pointers carry an extra wrap bit (IW+1 bits): empty when equal; full when only the MSB differs.
// - Allocation: when alloc_valid_i && alloc_ready_o, write entry tail, clear completed, tail++.
//   A request seen while not ready is dropped silently; decode must hold it.
// - Writeback: a port writes only when its target entry is valid; writes to flushed entries are ignored.
//   Two ports hitting one entry is illegal; the higher port index wins.
//   Completion is visible to commit the next cycle.
// - Commit (combinational from registered state): slot k is valid iff entries head..head+k are all
//   valid and completed, and no slot j<k redirects. Head advances by the popcount of cm_valid_o.
// - Redirect: the redirecting slot still commits. Next cycle every younger entry is invalid,
//   head = tail = 0, and count = 0. discard_sb_o sets the bit for each flushed valid store.
//   Allocation in the redirect cycle is blocked.
// - Simultaneous alloc and commit without redirect: count changes by 1 - commits.
//   A full ROB that commits this cycle still reports full_o; no same-cycle reuse.
// - Lookup: scan tail-1 down to head; first valid, we=1 entry with rd == rs and rd != 0 wins.
//   x0 never hits. If a WB port completes that entry this cycle, rs_ready_o = 1 and
//   rs_data_o = that port's result.
// - Wrap-around: indices are taken modulo ROB_DEPTH; a full ROB must scan all ROB_DEPTH entries.
// - Reset mid-operation: all state clears asynchronously; no commit or discard is emitted.
// CONFIGURATION
// ROB_STATS_EN defined: adds 32-bit saturating counters and ports stat_commits_o,
//   stat_redirects_o and stat_full_cycles_o (out, 32 each). Counters reset to 0.
//   stat_commits_o adds the popcount of cm_valid_o each cycle.
// ROB_STATS_EN undefined: no counters and no stat ports; all other behaviour is identical.
// TESTING
// 1 Reset, then 16 allocs with no WB -> full_o=1, count_o=16, alloc_ready_o=0; the 17th request is dropped.
// 2 Alloc idx 0..2; WB 2, then 0, then 1 -> cm_valid_o=0 until idx1 completes; next cycle cm_valid_o=2'b11 (0,1), then 2'b01 (2).
// 3 Alloc 4 entries incl. a store at idx3 (sb slot 5); idx1 completes with taken=1, new_pc=0x80
//   -> redirect_o=1, redirect_pc_o=0x80, discard_sb_o[5]=1; next cycle count_o=0.
// 4 Exception on idx0 -> redirect_pc_o=XCPT_ADDR; cm_valid_o=2'b01 even though idx1 is completed.
// 5 idx4 (rd=x7) and idx6 (rd=x7) in flight; lookup x7 -> rs_idx_o=6. WB to idx6 same cycle with 0xDEAD
//   -> rs_ready_o=1, rs_data_o=0xDEAD. Lookup x0 -> rs_hit_o=0.
// 6 Cycle head across index 15->0 with 40 allocs and commits -> in-order commits, no spurious full_o;
//   with ROB_STATS_EN, stat_commits_o=40.

Source files
------------

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with WB_PORTS completion ports, up to COMMIT_WIDTH in-order
// commits per cycle and bypassed operand lookup. Define ROB_STATS_EN to add statistics counters.
module rob_multi_commit #(
  parameter int unsigned ROB_DEPTH    = 16,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned WB_PORTS     = 2,
  parameter int unsigned SB_DEPTH     = 8,
  parameter logic [31:0] XCPT_ADDR    = 32'h0000_0200,
  localparam int unsigned IW = $clog2(ROB_DEPTH),
  localparam int unsigned SW = $clog2(SB_DEPTH),
  localparam int unsigned C  = COMMIT_WIDTH,
  localparam int unsigned P  = WB_PORTS
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                alloc_valid_i,
  input  logic [31:0]         alloc_pc_i,
  input  logic [4:0]          alloc_rd_i,
  input  logic                alloc_we_i,
  input  logic                alloc_store_i,
  output logic                alloc_ready_o,
  output logic [IW-1:0]       alloc_idx_o,
  input  logic [P-1:0]        wb_valid_i,
  input  logic [P*IW-1:0]     wb_idx_i,
  input  logic [P*32-1:0]     wb_result_i,
  input  logic [P*32-1:0]     wb_new_pc_i,
  input  logic [P-1:0]        wb_taken_i,
  input  logic [P-1:0]        wb_xcpt_i,
  input  logic [P*SW-1:0]     wb_sb_idx_i,
  output logic [C-1:0]        cm_valid_o,
  output logic [C*32-1:0]     cm_pc_o,
  output logic [C*5-1:0]      cm_rd_o,
  output logic [C-1:0]        cm_we_o,
  output logic [C*32-1:0]     cm_result_o,
  output logic [C-1:0]        cm_store_o,
  output logic [C*SW-1:0]     cm_sb_idx_o,
  output logic                redirect_o,
  output logic [31:0]         redirect_pc_o,
  output logic [SB_DEPTH-1:0] discard_sb_o,
  input  logic [2*5-1:0]      rs_addr_i,
  output logic [1:0]          rs_hit_o,
  output logic [2*IW-1:0]     rs_idx_o,
  output logic [1:0]          rs_ready_o,
  output logic [2*32-1:0]     rs_data_o,
  output logic [IW:0]         count_o,
  output logic                full_o
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]         stat_commits_o,
  output logic [31:0]         stat_redirects_o,
  output logic [31:0]         stat_full_cycles_o
`endif
);

  logic [IW:0]          r_head, r_tail;
  logic [ROB_DEPTH-1:0] r_valid, r_done, r_we, r_store, r_taken, r_xcpt;
  logic [31:0]          r_pc     [ROB_DEPTH];
  logic [31:0]          r_result [ROB_DEPTH];
  logic [31:0]          r_new_pc [ROB_DEPTH];
  logic [4:0]           r_rd     [ROB_DEPTH];
  logic [SW-1:0]        r_sb_idx [ROB_DEPTH];

  logic [ROB_DEPTH-1:0] w_cm_mask;
  logic [IW:0]          w_ncommit;
  logic                 w_alloc;

  assign count_o       = r_tail - r_head;
  assign full_o        = (count_o == (IW+1)'(ROB_DEPTH));
  assign alloc_ready_o = ~full_o & ~redirect_o;
  assign alloc_idx_o   = r_tail[IW-1:0];
  assign w_alloc       = alloc_valid_i & alloc_ready_o;

  // Commit walks from head; the first incomplete or redirecting slot ends the group.
  always_comb begin
    logic          run;
    logic [IW-1:0] idx;
    run           = 1'b1;
    idx           = '0;
    w_cm_mask     = '0;
    w_ncommit     = '0;
    cm_valid_o    = '0;
    cm_pc_o       = '0;
    cm_rd_o       = '0;
    cm_we_o       = '0;
    cm_result_o   = '0;
    cm_store_o    = '0;
    cm_sb_idx_o   = '0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    for (int k = 0; k < C; k++) begin
      idx = r_head[IW-1:0] + IW'(k);
      if (run && r_valid[idx] && r_done[idx]) begin
        cm_valid_o[k]            = 1'b1;
        w_cm_mask[idx]           = 1'b1;
        w_ncommit                = w_ncommit + (IW+1)'(1);
        cm_pc_o[k*32 +: 32]      = r_pc[idx];
        cm_rd_o[k*5 +: 5]        = r_rd[idx];
        cm_we_o[k]               = r_we[idx];
        cm_result_o[k*32 +: 32]  = r_result[idx];
        cm_store_o[k]            = r_store[idx];
        cm_sb_idx_o[k*SW +: SW]  = r_sb_idx[idx];
        if (r_taken[idx] || r_xcpt[idx]) begin
          run           = 1'b0;
          redirect_o    = 1'b1;
          redirect_pc_o = r_xcpt[idx] ? XCPT_ADDR : r_new_pc[idx];
        end
      end else begin
        run = 1'b0;
      end
    end
  end

  // Only stores that already hold a store-buffer slot have anything to discard.
  always_comb begin
    discard_sb_o = '0;
    if (redirect_o) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (r_valid[i] && r_store[i] && r_done[i] && !w_cm_mask[i]) begin
          discard_sb_o[r_sb_idx[i]] = 1'b1;
        end
      end
    end
  end

  // Scanning oldest to youngest and overwriting leaves the youngest producer.
  always_comb begin
    logic [IW-1:0] idx;
    logic [4:0]    rs;
    idx        = '0;
    rs         = '0;
    rs_hit_o   = '0;
    rs_idx_o   = '0;
    rs_ready_o = '0;
    rs_data_o  = '0;
    for (int s = 0; s < 2; s++) begin
      rs = rs_addr_i[s*5 +: 5];
      for (int i = 0; i < ROB_DEPTH; i++) begin
        idx = r_head[IW-1:0] + IW'(i);
        if (r_valid[idx] && r_we[idx] && (r_rd[idx] == rs) && (rs != 5'd0)) begin
          rs_hit_o[s]             = 1'b1;
          rs_idx_o[s*IW +: IW]    = idx;
          rs_ready_o[s]           = r_done[idx];
          rs_data_o[s*32 +: 32]   = r_result[idx];
        end
      end
      if (rs_hit_o[s]) begin
        for (int p = 0; p < P; p++) begin
          if (wb_valid_i[p] && (wb_idx_i[p*IW +: IW] == rs_idx_o[s*IW +: IW])) begin
            rs_ready_o[s]         = 1'b1;
            rs_data_o[s*32 +: 32] = wb_result_i[p*32 +: 32];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_we    <= '0;
      r_store <= '0;
      r_taken <= '0;
      r_xcpt  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_pc[i]     <= '0;
        r_result[i] <= '0;
        r_new_pc[i] <= '0;
        r_rd[i]     <= '0;
        r_sb_idx[i] <= '0;
      end
    end else begin
      // Ascending port order lets the higher port win on a collision.
      for (int p = 0; p < P; p++) begin
        if (wb_valid_i[p] && r_valid[wb_idx_i[p*IW +: IW]]) begin
          r_done[wb_idx_i[p*IW +: IW]]   <= 1'b1;
          r_result[wb_idx_i[p*IW +: IW]] <= wb_result_i[p*32 +: 32];
          r_new_pc[wb_idx_i[p*IW +: IW]] <= wb_new_pc_i[p*32 +: 32];
          r_taken[wb_idx_i[p*IW +: IW]]  <= wb_taken_i[p];
          r_xcpt[wb_idx_i[p*IW +: IW]]   <= wb_xcpt_i[p];
          r_sb_idx[wb_idx_i[p*IW +: IW]] <= wb_sb_idx_i[p*SW +: SW];
        end
      end
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (w_cm_mask[i]) r_valid[i] <= 1'b0;
      end
      r_head <= r_head + w_ncommit;
      if (w_alloc) begin
        r_valid[r_tail[IW-1:0]] <= 1'b1;
        r_done[r_tail[IW-1:0]]  <= 1'b0;
        r_taken[r_tail[IW-1:0]] <= 1'b0;
        r_xcpt[r_tail[IW-1:0]]  <= 1'b0;
        r_pc[r_tail[IW-1:0]]    <= alloc_pc_i;
        r_rd[r_tail[IW-1:0]]    <= alloc_rd_i;
        r_we[r_tail[IW-1:0]]    <= alloc_we_i;
        r_store[r_tail[IW-1:0]] <= alloc_store_i;
        r_tail                  <= r_tail + (IW+1)'(1);
      end
      if (redirect_o) begin
        r_valid <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end
    end
  end

`ifdef ROB_STATS_EN
  logic [31:0] r_stat_commits, r_stat_redirects, r_stat_full_cycles;
  logic [32:0] w_commits_sum;

  assign w_commits_sum = {1'b0, r_stat_commits} + 33'(w_ncommit);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stat_commits     <= '0;
      r_stat_redirects   <= '0;
      r_stat_full_cycles <= '0;
    end else begin
      r_stat_commits <= w_commits_sum[32] ? '1 : w_commits_sum[31:0];
      if (redirect_o && (r_stat_redirects != '1)) r_stat_redirects <= r_stat_redirects + 32'd1;
      if (full_o && (r_stat_full_cycles != '1)) r_stat_full_cycles <= r_stat_full_cycles + 32'd1;
    end
  end

  assign stat_commits_o     = r_stat_commits;
  assign stat_redirects_o   = r_stat_redirects;
  assign stat_full_cycles_o = r_stat_full_cycles;
`endif

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: directed stimulus against a queue-based model of the reorder buffer,
// checked every cycle, plus hand-computed literal expectations.
module tb_rob_multi_commit;
  localparam int DEPTH = 16;
  localparam int C     = 2;
  localparam int P     = 2;
  localparam int SB    = 8;
  localparam int IW    = 4;
  localparam int SW    = 3;
  localparam logic [31:0] XCPT = 32'h0000_0200;

  logic              clk_i, rstn_i;
  logic              alloc_valid_i, alloc_we_i, alloc_store_i;
  logic [31:0]       alloc_pc_i;
  logic [4:0]        alloc_rd_i;
  logic              alloc_ready_o;
  logic [IW-1:0]     alloc_idx_o;
  logic [P-1:0]      wb_valid_i, wb_taken_i, wb_xcpt_i;
  logic [P*IW-1:0]   wb_idx_i;
  logic [P*32-1:0]   wb_result_i, wb_new_pc_i;
  logic [P*SW-1:0]   wb_sb_idx_i;
  logic [C-1:0]      cm_valid_o, cm_we_o, cm_store_o;
  logic [C*32-1:0]   cm_pc_o, cm_result_o;
  logic [C*5-1:0]    cm_rd_o;
  logic [C*SW-1:0]   cm_sb_idx_o;
  logic              redirect_o;
  logic [31:0]       redirect_pc_o;
  logic [SB-1:0]     discard_sb_o;
  logic [9:0]        rs_addr_i;
  logic [1:0]        rs_hit_o, rs_ready_o;
  logic [2*IW-1:0]   rs_idx_o;
  logic [63:0]       rs_data_o;
  logic [IW:0]       count_o;
  logic              full_o;
`ifdef ROB_STATS_EN
  logic [31:0]       stat_commits_o, stat_redirects_o, stat_full_cycles_o;
`endif

  rob_multi_commit dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_rd_i(alloc_rd_i),
    .alloc_we_i(alloc_we_i), .alloc_store_i(alloc_store_i),
    .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .wb_new_pc_i(wb_new_pc_i), .wb_taken_i(wb_taken_i), .wb_xcpt_i(wb_xcpt_i),
    .wb_sb_idx_i(wb_sb_idx_i),
    .cm_valid_o(cm_valid_o), .cm_pc_o(cm_pc_o), .cm_rd_o(cm_rd_o), .cm_we_o(cm_we_o),
    .cm_result_o(cm_result_o), .cm_store_o(cm_store_o), .cm_sb_idx_o(cm_sb_idx_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .discard_sb_o(discard_sb_o),
    .rs_addr_i(rs_addr_i), .rs_hit_o(rs_hit_o), .rs_idx_o(rs_idx_o),
    .rs_ready_o(rs_ready_o), .rs_data_o(rs_data_o),
    .count_o(count_o), .full_o(full_o)
`ifdef ROB_STATS_EN
    , .stat_commits_o(stat_commits_o), .stat_redirects_o(stat_redirects_o),
    .stat_full_cycles_o(stat_full_cycles_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int obs_commits = 0;
  logic [31:0] last_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // In-flight instructions, oldest first.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   pc;
    logic [4:0]    rd;
    logic          we, st, done, tk, xc;
    logic [31:0]   res, npc;
    logic [SW-1:0] sb;
  } ent_t;

  typedef struct packed {
    logic [C-1:0]    cmv;
    logic [C*32-1:0] pc, res;
    logic [C*5-1:0]  rd;
    logic [C-1:0]    we, st;
    logic [C*SW-1:0] sb;
    logic            redir;
    logic [31:0]     rpc;
    logic [SB-1:0]   discard;
    logic [IW:0]     count;
    logic            full, ready;
    logic [IW-1:0]   aidx;
    logic [1:0]      hit, rrdy;
    logic [2*IW-1:0] ridx;
    logic [63:0]     rdata;
    logic [31:0]     ncommit;
  } exp_t;

  ent_t          q[$];
  logic [IW-1:0] m_tail;

  function automatic exp_t model_out();
    exp_t e;
    logic stop, found;
    logic [4:0] rs;
    int n;
    e = '0; stop = 1'b0; n = 0;
    for (int k = 0; k < C; k++) begin
      if (!stop && k < q.size() && q[k].done) begin
        e.cmv[k] = 1'b1;
        e.pc[k*32 +: 32]  = q[k].pc;
        e.res[k*32 +: 32] = q[k].res;
        e.rd[k*5 +: 5]    = q[k].rd;
        e.we[k] = q[k].we;
        e.st[k] = q[k].st;
        e.sb[k*SW +: SW]  = q[k].sb;
        n++;
        if (q[k].tk || q[k].xc) begin
          stop = 1'b1; e.redir = 1'b1;
          e.rpc = q[k].xc ? XCPT : q[k].npc;
        end
      end else stop = 1'b1;
    end
    e.ncommit = 32'(n);
    if (e.redir)
      for (int j = n; j < q.size(); j++)
        if (q[j].st && q[j].done) e.discard[q[j].sb] = 1'b1;
    e.count = 5'(q.size());
    e.full  = (q.size() == DEPTH);
    e.ready = !e.full && !e.redir;
    e.aidx  = m_tail;
    for (int s = 0; s < 2; s++) begin
      rs = rs_addr_i[s*5 +: 5];
      found = 1'b0;
      if (rs != 5'd0)
        for (int j = q.size() - 1; j >= 0; j--)
          if (!found && q[j].we && q[j].rd == rs) begin
            found = 1'b1;
            e.hit[s] = 1'b1;
            e.ridx[s*IW +: IW] = q[j].idx;
            e.rrdy[s] = q[j].done;
            e.rdata[s*32 +: 32] = q[j].res;
          end
      if (found)
        for (int p = 0; p < P; p++)
          if (wb_valid_i[p] && wb_idx_i[p*IW +: IW] == e.ridx[s*IW +: IW]) begin
            e.rrdy[s] = 1'b1;
            e.rdata[s*32 +: 32] = wb_result_i[p*32 +: 32];
          end
    end
    return e;
  endfunction

  exp_t m_upd, m_cmp;
  ent_t tmp;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      q.delete();
      m_tail = '0;
    end else begin
      m_upd = model_out();
      for (int p = 0; p < P; p++)
        if (wb_valid_i[p])
          for (int j = 0; j < q.size(); j++)
            if (q[j].idx == wb_idx_i[p*IW +: IW]) begin
              tmp = q[j];
              tmp.done = 1'b1;
              tmp.res  = wb_result_i[p*32 +: 32];
              tmp.npc  = wb_new_pc_i[p*32 +: 32];
              tmp.tk   = wb_taken_i[p];
              tmp.xc   = wb_xcpt_i[p];
              tmp.sb   = wb_sb_idx_i[p*SW +: SW];
              q[j] = tmp;
            end
      for (int k = 0; k < int'(m_upd.ncommit); k++) void'(q.pop_front());
      if (m_upd.redir) begin
        q.delete();
        m_tail = '0;
      end else if (alloc_valid_i && m_upd.ready) begin
        tmp = '0;
        tmp.idx = m_tail; tmp.pc = alloc_pc_i; tmp.rd = alloc_rd_i;
        tmp.we = alloc_we_i; tmp.st = alloc_store_i;
        q.push_back(tmp);
        m_tail = m_tail + 4'd1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (rstn_i) begin
      m_cmp = model_out();
      check("cm_valid", 64'(cm_valid_o), 64'(m_cmp.cmv));
      for (int k = 0; k < C; k++) begin
        if (m_cmp.cmv[k]) begin
          check($sformatf("cm_pc%0d", k), 64'(cm_pc_o[k*32 +: 32]), 64'(m_cmp.pc[k*32 +: 32]));
          check($sformatf("cm_rd%0d", k), 64'(cm_rd_o[k*5 +: 5]), 64'(m_cmp.rd[k*5 +: 5]));
          check($sformatf("cm_we%0d", k), 64'(cm_we_o[k]), 64'(m_cmp.we[k]));
          check($sformatf("cm_res%0d", k), 64'(cm_result_o[k*32 +: 32]),
                64'(m_cmp.res[k*32 +: 32]));
          check($sformatf("cm_st%0d", k), 64'(cm_store_o[k]), 64'(m_cmp.st[k]));
          if (m_cmp.st[k])
            check($sformatf("cm_sb%0d", k), 64'(cm_sb_idx_o[k*SW +: SW]),
                  64'(m_cmp.sb[k*SW +: SW]));
        end
      end
      check("redirect", 64'(redirect_o), 64'(m_cmp.redir));
      if (m_cmp.redir) check("redirect_pc", 64'(redirect_pc_o), 64'(m_cmp.rpc));
      check("discard", 64'(discard_sb_o), 64'(m_cmp.discard));
      check("count", 64'(count_o), 64'(m_cmp.count));
      check("full", 64'(full_o), 64'(m_cmp.full));
      check("alloc_ready", 64'(alloc_ready_o), 64'(m_cmp.ready));
      check("alloc_idx", 64'(alloc_idx_o), 64'(m_cmp.aidx));
      for (int s = 0; s < 2; s++) begin
        check($sformatf("rs_hit%0d", s), 64'(rs_hit_o[s]), 64'(m_cmp.hit[s]));
        if (m_cmp.hit[s]) begin
          check($sformatf("rs_idx%0d", s), 64'(rs_idx_o[s*IW +: IW]), 64'(m_cmp.ridx[s*IW +: IW]));
          check($sformatf("rs_ready%0d", s), 64'(rs_ready_o[s]), 64'(m_cmp.rrdy[s]));
          if (m_cmp.rrdy[s])
            check($sformatf("rs_data%0d", s), 64'(rs_data_o[s*32 +: 32]),
                  64'(m_cmp.rdata[s*32 +: 32]));
        end
      end
      for (int k = 0; k < C; k++)
        if (cm_valid_o[k]) begin
          obs_commits++;
          last_pc = cm_pc_o[k*32 +: 32];
        end
    end
  end

  task automatic idle();
    alloc_valid_i = 1'b0; alloc_pc_i = '0; alloc_rd_i = '0; alloc_we_i = 1'b0;
    alloc_store_i = 1'b0;
    wb_valid_i = '0; wb_idx_i = '0; wb_result_i = '0; wb_new_pc_i = '0;
    wb_taken_i = '0; wb_xcpt_i = '0; wb_sb_idx_i = '0;
    rs_addr_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1 idle();
    #1;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                       input logic st);
    alloc_valid_i = 1'b1; alloc_pc_i = pc; alloc_rd_i = rd; alloc_we_i = we; alloc_store_i = st;
  endtask

  task automatic wb(input int p, input logic [IW-1:0] idx, input logic [31:0] res,
                    input logic [31:0] npc, input logic tk, input logic xc,
                    input logic [SW-1:0] sb);
    wb_valid_i[p] = 1'b1;
    wb_idx_i[p*IW +: IW] = idx;
    wb_result_i[p*32 +: 32] = res;
    wb_new_pc_i[p*32 +: 32] = npc;
    wb_taken_i[p] = tk;
    wb_xcpt_i[p] = xc;
    wb_sb_idx_i[p*SW +: SW] = sb;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    idle();
    #1;
    @(posedge clk_i);
    #1 rstn_i = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  int base;

  initial begin
    idle();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(alloc_ready_o), 64'd1);
    check("rst_cm_valid", 64'(cm_valid_o), 64'd0);
    check("rst_redirect", 64'(redirect_o), 64'd0);
    check("rst_discard", 64'(discard_sb_o), 64'd0);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_alloc_idx", 64'(alloc_idx_o), 64'd0);
    rstn_i = 1'b1;
    #1;

    // Fill to full; the 17th request is dropped.
    for (int i = 0; i < 16; i++) begin
      alloc(32'h1000 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0);
      step();
    end
    check("t1_count", 64'(count_o), 64'd16);
    check("t1_full", 64'(full_o), 64'd1);
    check("t1_ready", 64'(alloc_ready_o), 64'd0);
    alloc(32'h2000, 5'd20, 1'b1, 1'b0);
    step();
    check("t1_drop_count", 64'(count_o), 64'd16);
    check("t1_alloc_idx", 64'(alloc_idx_o), 64'd0);
    rs_addr_i = {5'd16, 5'd1};
    #1;
    check("t1_rs_hit", 64'(rs_hit_o), 64'd3);
    check("t1_rs_idx", 64'(rs_idx_o), 64'hF0);
    rstn_i = 1'b0;
    #1;
    check("t1_midrst_count", 64'(count_o), 64'd0);
    check("t1_midrst_full", 64'(full_o), 64'd0);

    // Out-of-order completion, two-wide commit.
    do_reset();
    alloc(32'h100, 5'd1, 1'b1, 1'b0); step();
    alloc(32'h104, 5'd2, 1'b1, 1'b0); step();
    alloc(32'h108, 5'd3, 1'b1, 1'b0); step();
    wb(0, 4'd2, 32'h22, 32'h0, 1'b0, 1'b0, 3'd0);
    step();
    check("t2_cm_none", 64'(cm_valid_o), 64'd0);
    wb(0, 4'd0, 32'h20, 32'h0, 1'b0, 1'b0, 3'd0);
    wb(1, 4'd1, 32'h21, 32'h0, 1'b0, 1'b0, 3'd0);
    step();
    check("t2_cm_both", 64'(cm_valid_o), 64'd3);
    check("t2_cm_pc", 64'(cm_pc_o), 64'h0000_0104_0000_0100);
    check("t2_cm_res1", 64'(cm_result_o[63:32]), 64'h21);
    step();
    check("t2_cm_one", 64'(cm_valid_o), 64'd1);
    check("t2_cm_pc2", 64'(cm_pc_o[31:0]), 64'h108);
    check("t2_cm_res2", 64'(cm_result_o[31:0]), 64'h22);
    step();
    check("t2_empty", 64'(count_o), 64'd0);

    // Taken branch flushes a completed store.
    do_reset();
    alloc(32'h200, 5'd1, 1'b1, 1'b0); step();
    alloc(32'h204, 5'd0, 1'b0, 1'b0); step();
    alloc(32'h208, 5'd2, 1'b1, 1'b0); step();
    alloc(32'h20C, 5'd0, 1'b0, 1'b1); step();
    wb(0, 4'd3, 32'h0, 32'h0, 1'b0, 1'b0, 3'd5);
    step();
    wb(0, 4'd1, 32'h11, 32'h80, 1'b1, 1'b0, 3'd0);
    wb(1, 4'd0, 32'h10, 32'h0, 1'b0, 1'b0, 3'd0);
    step();
    alloc(32'h300, 5'd9, 1'b1, 1'b0);
    #1;
    check("t3_cm_valid", 64'(cm_valid_o), 64'd3);
    check("t3_redirect", 64'(redirect_o), 64'd1);
    check("t3_redirect_pc", 64'(redirect_pc_o), 64'h80);
    check("t3_discard", 64'(discard_sb_o), 64'h20);
    check("t3_ready", 64'(alloc_ready_o), 64'd0);
    step();
    check("t3_count", 64'(count_o), 64'd0);
    check("t3_alloc_idx", 64'(alloc_idx_o), 64'd0);

    // Exception stops the group even though the next entry completed.
    do_reset();
    alloc(32'h500, 5'd1, 1'b1, 1'b0); step();
    alloc(32'h504, 5'd2, 1'b1, 1'b0); step();
    wb(0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 3'd0);
    wb(1, 4'd1, 32'h5, 32'h0, 1'b0, 1'b0, 3'd0);
    step();
    check("t4_cm_valid", 64'(cm_valid_o), 64'd1);
    check("t4_redirect_pc", 64'(redirect_pc_o), 64'(XCPT));
    step();
    check("t4_count", 64'(count_o), 64'd0);

    // Youngest producer wins; writeback bypass; x0 never hits.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      alloc(32'h300 + 32'(4 * i), (i == 4 || i == 6) ? 5'd7 : 5'(10 + i), 1'b1, 1'b0);
      step();
    end
    rs_addr_i = {5'd0, 5'd7};
    #1;
    check("t5_hit", 64'(rs_hit_o), 64'd1);
    check("t5_idx", 64'(rs_idx_o[3:0]), 64'd6);
    check("t5_not_ready", 64'(rs_ready_o[0]), 64'd0);
    wb(1, 4'd6, 32'hDEAD, 32'h0, 1'b0, 1'b0, 3'd0);
    #1;
    check("t5_bypass_ready", 64'(rs_ready_o[0]), 64'd1);
    check("t5_bypass_data", 64'(rs_data_o[31:0]), 64'hDEAD);
    step();
    rs_addr_i = {5'd0, 5'd7};
    #1;
    check("t5_reg_data", 64'(rs_data_o[31:0]), 64'hDEAD);

    // Stream 40 instructions so head wraps 15->0 twice.
    do_reset();
    base = obs_commits;
    for (int t = 0; t < 40; t++) begin
      alloc(32'h4000 + 32'(4 * t), 5'(t % 31 + 1), 1'b1, 1'b0);
      if (t >= 2 && t % 2 == 0) begin
        wb(0, 4'((t - 2) % 16), 32'(t - 2), 32'h0, 1'b0, 1'b0, 3'd0);
        wb(1, 4'((t - 1) % 16), 32'(t - 1), 32'h0, 1'b0, 1'b0, 3'd0);
      end
      step();
    end
    wb(0, 4'd6, 32'd38, 32'h0, 1'b0, 1'b0, 3'd0);
    wb(1, 4'd7, 32'd39, 32'h0, 1'b0, 1'b0, 3'd0);
    step();
    repeat (4) step();
    check("t6_commits", 64'(obs_commits - base), 64'd40);
    check("t6_last_pc", 64'(last_pc), 64'h409C);
    check("t6_count", 64'(count_o), 64'd0);
`ifdef ROB_STATS_EN
    check("t6_stat_commits", 64'(stat_commits_o), 64'd40);
    check("t6_stat_redirects", 64'(stat_redirects_o), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
